// File: rtl/branch_pc_unit.sv
// Branch resolution and architectural PC owner.
// Decodes the branch condition from BrEq/BrLT, computes redirect targets,
// sequences the post-redirect flush and parks in HALT on a misaligned target
// until the trap is acknowledged. Also keeps saturating branch statistics.
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC    = 32'h0000_0100,
  parameter int          FLUSH_DEPTH = 2,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             ex_valid,
  input  logic             ex_branch,
  input  logic             ex_jal,
  input  logic             ex_jalr,
  input  logic [2:0]       ex_funct3,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_imm,
  input  logic [31:0]      ex_rs1,
  input  logic             BrEq,
  input  logic             BrLT,
  output logic             BrUn,
  output logic [31:0]      pc,
  output logic             flush,
  output logic             trap_misalign,
  input  logic             trap_ack,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [1:0]       dbg_state
);

  // Handshake note: there is no valid/ready pair here. An EX instruction is
  // consumed in the cycle it is presented with ex_valid=1, provided stall=0
  // and the unit is in RUN; in FLUSH and HALT it is treated as killed.

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam logic [2:0] FCNT_INIT = 3'(FLUSH_DEPTH - 1);

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             flush_q, flush_d;
  logic             trap_q, trap_d;
  logic [2:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;

  logic             cond;
  logic             legal_f3;
  logic             take;
  logic             misalign;
  logic             cnt_en;
  logic [31:0]      target;

  // Unsigned compare select goes straight back to the comparator.
  assign BrUn = ex_funct3[1];

  // Branch condition decode; funct3[0] inverts the base compare.
  always_comb begin
    cond     = 1'b0;
    legal_f3 = (ex_funct3[2:1] != 2'b01);
    if (ex_funct3[2]) begin
      cond = BrLT ^ ex_funct3[0];
    end else if (!ex_funct3[1]) begin
      cond = BrEq ^ ex_funct3[0];
    end
  end

  // Redirect target, jalr taking priority over jal over branch.
  always_comb begin
    target = ex_pc + ex_imm;
    if (ex_jalr) begin
      target = (ex_rs1 + ex_imm) & ~32'h1;
    end
  end

  assign take     = ex_valid & (ex_jal | ex_jalr | (ex_branch & cond));
  assign misalign = take & target[1];
  assign cnt_en   = ex_valid & ex_branch & legal_f3;

  // Next-state, PC, flush and statistics logic; stall freezes everything.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flush_d = flush_q;
    trap_d  = trap_q;
    fcnt_d  = fcnt_q;
    bcnt_d  = bcnt_q;
    tcnt_d  = tcnt_q;
    if (!stall) begin
      case (state_q)
        ST_RUN: begin
          if (misalign) begin
            pc_d    = TRAP_VEC;
            flush_d = 1'b1;
            trap_d  = 1'b1;
            state_d = ST_HALT;
          end else if (take) begin
            pc_d    = target;
            flush_d = 1'b1;
            fcnt_d  = FCNT_INIT;
            // A single-cycle flush needs no FLUSH visit at all.
            state_d = (FCNT_INIT == 3'd0) ? ST_RUN : ST_FLUSH;
          end else begin
            pc_d    = pc_q + 32'd4;
            flush_d = 1'b0;
          end
          if (cnt_en) begin
            if (bcnt_q != '1) bcnt_d = bcnt_q + 1'b1;
            if (cond && (tcnt_q != '1)) tcnt_d = tcnt_q + 1'b1;
          end
        end
        ST_FLUSH: begin
          pc_d = pc_q + 32'd4;
          if (fcnt_q == 3'd0) begin
            flush_d = 1'b0;
            state_d = ST_RUN;
          end else begin
            fcnt_d = fcnt_q - 3'd1;
          end
        end
        ST_HALT: begin
          if (trap_ack) begin
            trap_d  = 1'b0;
            flush_d = 1'b0;
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_RUN;
          flush_d = 1'b0;
          trap_d  = 1'b0;
        end
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
      trap_q  <= 1'b0;
      fcnt_q  <= 3'd0;
      bcnt_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
      trap_q  <= trap_d;
      fcnt_q  <= fcnt_d;
      bcnt_q  <= bcnt_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign pc            = pc_q;
  assign flush         = flush_q;
  assign trap_misalign = trap_q;
  assign branch_cnt    = bcnt_q;
  assign taken_cnt     = tcnt_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit: expected per-cycle outputs are queued by
// the driver and compared by an independent monitor after each rising edge.
module tb_branch_pc_unit;

  localparam int CNT_W = 4;
  localparam int EW    = 32 + 1 + 1 + CNT_W + CNT_W + 2;
  localparam logic [1:0] S_RUN = 2'd0, S_FLUSH = 2'd1, S_HALT = 2'd2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             stall;
  logic             ex_valid, ex_branch, ex_jal, ex_jalr;
  logic [2:0]       ex_funct3;
  logic [31:0]      ex_pc, ex_imm, ex_rs1;
  logic             BrEq, BrLT, BrUn;
  logic [31:0]      pc;
  logic             flush, trap_misalign, trap_ack;
  logic [CNT_W-1:0] branch_cnt, taken_cnt;
  logic [1:0]       dbg_state;

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int step_no  = 0;

  branch_pc_unit #(
    .RESET_PC   (32'h0000_0000),
    .TRAP_VEC   (32'h0000_0100),
    .FLUSH_DEPTH(2),
    .CNT_W      (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .ex_valid     (ex_valid),
    .ex_branch    (ex_branch),
    .ex_jal       (ex_jal),
    .ex_jalr      (ex_jalr),
    .ex_funct3    (ex_funct3),
    .ex_pc        (ex_pc),
    .ex_imm       (ex_imm),
    .ex_rs1       (ex_rs1),
    .BrEq         (BrEq),
    .BrLT         (BrLT),
    .BrUn         (BrUn),
    .pc           (pc),
    .flush        (flush),
    .trap_misalign(trap_misalign),
    .trap_ack     (trap_ack),
    .branch_cnt   (branch_cnt),
    .taken_cnt    (taken_cnt),
    .dbg_state    (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s (step %0d): got 0x%08h, expected 0x%08h", name, step_no, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Monitor: after every rising edge, compare against the oldest expectation.
  always @(posedge clk) begin
    logic [EW-1:0] e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      step_no++;
      chk("pc",         pc,                     e[EW-1 -: 32]);
      chk("flush",      {31'd0, flush},         {31'd0, e[EW-33]});
      chk("trap",       {31'd0, trap_misalign}, {31'd0, e[EW-34]});
      chk("branch_cnt", 32'(branch_cnt),        32'(e[2*CNT_W+1 -: CNT_W]));
      chk("taken_cnt",  32'(taken_cnt),         32'(e[CNT_W+1 -: CNT_W]));
      chk("state",      32'(dbg_state),         32'(e[1:0]));
    end
  end

  // Driver tasks
  task automatic idle();
    ex_valid = 1'b0; ex_branch = 1'b0; ex_jal = 1'b0; ex_jalr = 1'b0;
    ex_funct3 = 3'b000; ex_pc = '0; ex_imm = '0; ex_rs1 = '0;
    BrEq = 1'b0; BrLT = 1'b0;
  endtask

  task automatic set_br(input logic [2:0] f3, input logic [31:0] p, input logic [31:0] imm,
                        input logic eq, input logic lt);
    idle();
    ex_valid = 1'b1; ex_branch = 1'b1; ex_funct3 = f3;
    ex_pc = p; ex_imm = imm; BrEq = eq; BrLT = lt;
  endtask

  task automatic set_jump(input logic jal, input logic jalr, input logic [31:0] p,
                          input logic [31:0] imm, input logic [31:0] rs1);
    idle();
    ex_valid = 1'b1; ex_jal = jal; ex_jalr = jalr;
    ex_pc = p; ex_imm = imm; ex_rs1 = rs1;
  endtask

  // Queue the outputs expected after the coming rising edge, then advance.
  task automatic step(input logic [31:0] p, input logic f, input logic t,
                      input logic [CNT_W-1:0] bc, input logic [CNT_W-1:0] tc,
                      input logic [1:0] st);
    exp_q.push_back({p, f, t, bc, tc, st});
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    #1;
    chk({tag, "_pc"},    pc, 32'h0);
    chk({tag, "_flush"}, {31'd0, flush}, 32'd0);
    chk({tag, "_trap"},  {31'd0, trap_misalign}, 32'd0);
    chk({tag, "_bcnt"},  32'(branch_cnt), 32'd0);
    chk({tag, "_tcnt"},  32'(taken_cnt), 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(S_RUN));
  endtask

  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    check_reset_outputs(tag);
    idle();
    stall = 1'b0; trap_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [CNT_W-1:0] bc, tc;
    rst_n = 1'b0; stall = 1'b0; trap_ack = 1'b0;
    idle();
    check_reset_outputs("init");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential fetch up to 0x40
    for (int i = 1; i <= 16; i++) step(32'(i * 4), 0, 0, 4'd0, 4'd0, S_RUN);

    // BEQ taken: 0x20+0x10; branch held during flush must be ignored
    set_br(3'b000, 32'h20, 32'h10, 1'b1, 1'b0);
    #1 chk("brun_beq", {31'd0, BrUn}, 32'd0);
    step(32'h30, 1, 0, 4'd1, 4'd1, S_FLUSH);
    step(32'h34, 1, 0, 4'd1, 4'd1, S_FLUSH);
    step(32'h38, 0, 0, 4'd1, 4'd1, S_RUN);

    // BGEU with BrLT=1: not taken
    set_br(3'b111, 32'h38, 32'h100, 1'b0, 1'b1);
    #1 chk("brun_bgeu", {31'd0, BrUn}, 32'd1);
    step(32'h3C, 0, 0, 4'd2, 4'd1, S_RUN);

    // BLT taken backwards, then stall 3 cycles inside the flush
    set_br(3'b100, 32'h3C, 32'hFFFF_FFF8, 1'b0, 1'b1);
    step(32'h34, 1, 0, 4'd3, 4'd2, S_FLUSH);
    idle(); stall = 1'b1;
    for (int i = 0; i < 3; i++) step(32'h34, 1, 0, 4'd3, 4'd2, S_FLUSH);
    stall = 1'b0;
    step(32'h38, 1, 0, 4'd3, 4'd2, S_FLUSH);
    step(32'h3C, 0, 0, 4'd3, 4'd2, S_RUN);

    // Illegal funct3 010: not taken, not counted
    set_br(3'b010, 32'h3C, 32'h10, 1'b1, 1'b1);
    step(32'h40, 0, 0, 4'd3, 4'd2, S_RUN);

    // Stall in RUN with a taken branch: nothing moves, nothing counted
    set_br(3'b000, 32'h40, 32'h10, 1'b1, 1'b0);
    stall = 1'b1;
    step(32'h40, 0, 0, 4'd3, 4'd2, S_RUN);
    stall = 1'b0; idle();
    step(32'h44, 0, 0, 4'd3, 4'd2, S_RUN);

    // JALR 0x1001 -> 0x1000, aligned
    set_jump(1'b0, 1'b1, 32'h44, 32'h0, 32'h1001);
    step(32'h1000, 1, 0, 4'd3, 4'd2, S_FLUSH);
    idle();
    step(32'h1004, 1, 0, 4'd3, 4'd2, S_FLUSH);
    step(32'h1008, 0, 0, 4'd3, 4'd2, S_RUN);

    // JALR 0x1002 -> misaligned trap, HALT ignores a taken JAL
    set_jump(1'b0, 1'b1, 32'h1008, 32'h0, 32'h1002);
    step(32'h100, 1, 1, 4'd3, 4'd2, S_HALT);
    set_jump(1'b1, 1'b0, 32'h0, 32'h40, 32'h0);
    step(32'h100, 1, 1, 4'd3, 4'd2, S_HALT);
    step(32'h100, 1, 1, 4'd3, 4'd2, S_HALT);
    idle(); trap_ack = 1'b1;
    step(32'h100, 0, 0, 4'd3, 4'd2, S_RUN);
    trap_ack = 1'b0;
    step(32'h104, 0, 0, 4'd3, 4'd2, S_RUN);
    trap_ack = 1'b1;
    step(32'h108, 0, 0, 4'd3, 4'd2, S_RUN);
    trap_ack = 1'b0;

    // JAL and JALR both set: JALR target wins
    set_jump(1'b1, 1'b1, 32'h108, 32'h20, 32'h2000);
    step(32'h2020, 1, 0, 4'd3, 4'd2, S_FLUSH);
    idle();
    step(32'h2024, 1, 0, 4'd3, 4'd2, S_FLUSH);
    step(32'h2028, 0, 0, 4'd3, 4'd2, S_RUN);

    // Plain JAL
    set_jump(1'b1, 1'b0, 32'h2028, 32'h10, 32'hDEAD_BEEF);
    step(32'h2038, 1, 0, 4'd3, 4'd2, S_FLUSH);
    idle();
    step(32'h203C, 1, 0, 4'd3, 4'd2, S_FLUSH);
    step(32'h2040, 0, 0, 4'd3, 4'd2, S_RUN);

    // Misaligned taken BNE counts in both counters
    set_br(3'b001, 32'h2040, 32'h6, 1'b0, 1'b0);
    step(32'h100, 1, 1, 4'd4, 4'd3, S_HALT);
    idle(); trap_ack = 1'b1;
    step(32'h100, 0, 0, 4'd4, 4'd3, S_RUN);
    trap_ack = 1'b0;

    // Not-taken branch with a misaligned target: no trap
    set_br(3'b000, 32'h100, 32'h2, 1'b0, 1'b0);
    step(32'h104, 0, 0, 4'd5, 4'd3, S_RUN);

    // Target wrap-around: 0xFFFF_FFFC + 8 = 0x4
    set_br(3'b000, 32'hFFFF_FFFC, 32'h8, 1'b1, 1'b0);
    step(32'h4, 1, 0, 4'd6, 4'd4, S_FLUSH);
    idle();
    step(32'h8, 1, 0, 4'd6, 4'd4, S_FLUSH);
    step(32'hC, 0, 0, 4'd6, 4'd4, S_RUN);

    // 20 taken BGE: counters saturate at 4'hF
    set_br(3'b101, 32'h200, 32'h0, 1'b0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      bc = (6 + k > 15) ? 4'hF : 4'(6 + k);
      tc = (4 + k > 15) ? 4'hF : 4'(4 + k);
      step(32'h200, 1, 0, bc, tc, S_FLUSH);
      step(32'h204, 1, 0, bc, tc, S_FLUSH);
      step(32'h208, 0, 0, bc, tc, S_RUN);
    end
    set_br(3'b101, 32'h208, 32'h0, 1'b0, 1'b1);
    step(32'h20C, 0, 0, 4'hF, 4'hF, S_RUN);

    // Reset asserted mid-FLUSH
    set_br(3'b000, 32'h20C, 32'h10, 1'b1, 1'b0);
    step(32'h21C, 1, 0, 4'hF, 4'hF, S_FLUSH);
    pulse_reset("rst_flush");
    step(32'h4, 0, 0, 4'd0, 4'd0, S_RUN);

    // Reset asserted in HALT
    set_jump(1'b0, 1'b1, 32'h4, 32'h0, 32'h2);
    step(32'h100, 1, 1, 4'd0, 4'd0, S_HALT);
    pulse_reset("rst_halt");
    step(32'h4, 0, 0, 4'd0, 4'd0, S_RUN);

    // Let the monitor drain the last expectation
    @(posedge clk);
    #3;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
